// File: rtl/wb_slave_mem_if.sv
// Wishbone B3 classic-cycle bundle between one interconnect slave port and its responder.
// Carries request, write data, byte selects, the busy input and the three terminations.
// The master drives the request side; the slave drives read data and terminations.
interface wb_slave_mem_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   adr_i;
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic [DW/8-1:0] sel_i;
  logic            we_i;
  logic            cyc_i;
  logic            stb_i;
  logic            busy_i;
  logic            ack_o;
  logic            err_o;
  logic            rty_o;

  modport master (
    output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, busy_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i, busy_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a word-addressed RAM with byte-lane writes.
// Latency: ack in cycle WAIT_STATES+1 after the request edge; err/rty in cycle 1.
// Backpressure: wait states stall the master; busy_i gives rty, a dropped strobe aborts.
module wb_slave_mem #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input logic         clk,
  input logic         rst,
  wb_slave_mem_if.slave wb
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {TERM_NONE, TERM_ACK, TERM_ERR, TERM_RTY} term_t;

  // Request captured in IDLE; later changes on the bus are ignored.
  typedef struct packed {
    logic                  we;
    logic [DW/8-1:0]       sel;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DW-1:0]         dat;
  } req_t;

  state_t          state, state_nx;
  term_t           term_nx;
  logic [3:0]      cnt, cnt_nx;
  req_t            req, req_nx;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   dat_q;
  logic            ack_q, err_q, rty_q;
  logic            req_vld;
  logic            adr_bad;

  assign req_vld = wb.cyc_i & wb.stb_i;
  // Beyond the RAM or not word aligned.
  assign adr_bad = (wb.adr_i[AW-1:DEPTH_LOG2+2] != '0) || (wb.adr_i[1:0] != 2'b00);

  assign wb.dat_o = dat_q;
  assign wb.ack_o = ack_q;
  assign wb.err_o = err_q;
  assign wb.rty_o = rty_q;

  // Next-state, wait countdown and termination classification.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req_nx   = req;
    term_nx  = TERM_NONE;
    unique case (state)
      IDLE: begin
        if (req_vld) begin
          req_nx.we  = wb.we_i;
          req_nx.sel = wb.sel_i;
          req_nx.idx = wb.adr_i[DEPTH_LOG2+1:2];
          req_nx.dat = wb.dat_i;
          if (wb.busy_i) begin
            state_nx = RESP;
            term_nx  = TERM_RTY;
          end else if (adr_bad) begin
            state_nx = RESP;
            term_nx  = TERM_ERR;
          end else if (WAIT_STATES == 0) begin
            state_nx = RESP;
            term_nx  = TERM_ACK;
          end else begin
            state_nx = WAIT;
            cnt_nx   = WS_LOAD;
          end
        end
      end
      WAIT: begin
        if (!req_vld) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = RESP;
          term_nx  = TERM_ACK;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, latched request and registered terminations (high for the whole RESP cycle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      req   <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      req   <= req_nx;
      ack_q <= (term_nx == TERM_ACK);
      err_q <= (term_nx == TERM_ERR);
      rty_q <= (term_nx == TERM_RTY);
    end
  end

  // Read data loaded on the edge entering an acked read, so it lines up with ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_q <= '0;
    end else if (term_nx == TERM_ACK && !req_nx.we) begin
      dat_q <= mem[req_nx.idx];
    end
  end

  // Write commits at the end of the ack cycle; a reset during RESP clears state and drops it.
  always_ff @(posedge clk) begin
    if (state == RESP && ack_q && req.we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (req.sel[b]) mem[req.idx][8*b +: 8] <= req.dat[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Bench for wb_slave_mem: directed cases plus randomized transfers against a word-array model.
// Main DUT uses two wait states; a second zero-wait instance checks back-to-back spacing.
module tb_wb_slave_mem;

  localparam int WS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_slave_mem_if #(.AW(32), .DW(32)) bus  ();
  wb_slave_mem_if #(.AW(32), .DW(32)) bus0 ();

  wb_slave_mem #(.AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_STATES(WS)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  wb_slave_mem #(.AW(32), .DW(32), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .wb  (bus0)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  int prev_t   = 0;
  int prev_t0  = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] model_dat;
  bit          model_dat_known;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Terminations must be one-hot and never in two consecutive cycles.
  always @(negedge clk) begin
    int t, t0;
    if (rst) begin
      prev_t  = 0;
      prev_t0 = 0;
    end else begin
      t  = int'(bus.ack_o) + int'(bus.err_o) + int'(bus.rty_o);
      t0 = int'(bus0.ack_o) + int'(bus0.err_o) + int'(bus0.rty_o);
      if (t > 1 || (t != 0 && prev_t != 0)) viol++;
      if (t0 > 1 || (t0 != 0 && prev_t0 != 0)) viol++;
      prev_t  = t;
      prev_t0 = t0;
    end
  end

  // One bus transfer; term 0=none 1=ack 2=err 3=rty, cyc_n = cycle of termination.
  task automatic xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input logic busy, input int abort_at,
                      output logic [1:0] term, output int cyc_n, output logic [31:0] rdat);
    term  = 2'd0;
    cyc_n = 0;
    rdat  = 32'd0;
    @(posedge clk); #1;
    bus.adr_i  = adr;
    bus.dat_i  = dat;
    bus.sel_i  = sel;
    bus.we_i   = we;
    bus.busy_i = busy;
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o || bus.rty_o) begin
        term  = bus.ack_o ? 2'd1 : (bus.err_o ? 2'd2 : 2'd3);
        cyc_n = n;
        rdat  = bus.dat_o;
        break;
      end
      if (n == abort_at) bus.stb_i = 1'b0;
    end
    @(posedge clk); #1;
    bus.cyc_i  = 1'b0;
    bus.stb_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.busy_i = 1'b0;
    bus.sel_i  = 4'h0;
  endtask

  // Transfer checked against the model: termination kind, latency, read data, RAM update.
  task automatic xact(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we, input logic busy,
                      output logic [1:0] term, output logic [31:0] rdat);
    int          idx, cyc_n, exp_cyc;
    logic        bad;
    logic [1:0]  exp_term;
    logic [31:0] w;
    idx      = int'(adr[11:2]);
    bad      = (adr[31:12] != 20'd0) || (adr[1:0] != 2'd0);
    exp_term = busy ? 2'd3 : (bad ? 2'd2 : 2'd1);
    exp_cyc  = (exp_term == 2'd1) ? WS + 1 : 1;
    xfer(adr, dat, sel, we, busy, -1, term, cyc_n, rdat);
    check({tag, "_term"}, 32'(term), 32'(exp_term));
    check({tag, "_cycle"}, 32'(cyc_n), 32'(exp_cyc));
    if (exp_term == 2'd1 && !we) begin
      if (ref_mem.exists(idx)) begin
        check({tag, "_rdata"}, rdat, ref_mem[idx]);
        model_dat       = ref_mem[idx];
        model_dat_known = 1'b1;
      end else begin
        model_dat_known = 1'b0;
      end
    end else if (exp_term == 2'd1 && we) begin
      w = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
      for (int b = 0; b < 4; b++) if (sel[b]) w[8*b +: 8] = dat[8*b +: 8];
      if (ref_mem.exists(idx) || sel == 4'hF) ref_mem[idx] = w;
      model_dat_known = 1'b0;
    end else if (model_dat_known) begin
      check({tag, "_dhold"}, rdat, model_dat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  term;
    logic [31:0] rdat, adr;
    logic [7:0]  pat;
    int          cyc_n, any_term, k, idx;

    bus.adr_i = '0;  bus.dat_i = '0;  bus.sel_i = '0;  bus.we_i = 1'b0;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.busy_i = 1'b0;
    bus0.adr_i = '0; bus0.dat_i = '0; bus0.sel_i = '0; bus0.we_i = 1'b0;
    bus0.cyc_i = 1'b0; bus0.stb_i = 1'b0; bus0.busy_i = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_err", 32'(bus.err_o), 32'd0);
    check("rst_rty", 32'(bus.rty_o), 32'd0);
    check("rst_dat", bus.dat_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_dat       = 32'd0;
    model_dat_known = 1'b1;

    // Known contents for the random window.
    for (int i = 0; i <= 16; i++) begin
      idx = (i == 16) ? 1023 : i;
      xact("pre", 32'(idx * 4), $urandom, 4'hF, 1'b1, 1'b0, term, rdat);
    end

    // Basic write then read with two wait states.
    xact("t1_wr", 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, term, rdat);
    xact("t1_rd", 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t1_value", rdat, 32'hDEADBEEF);

    // Byte lanes.
    xact("t2_wr", 32'h40, 32'h11223344, 4'hF, 1'b1, 1'b0, term, rdat);
    xact("t2_wsel", 32'h40, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, term, rdat);
    xact("t2_rd", 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, term, rdat);
    check("t2_value", rdat, 32'h11BB33DD);
    xact("t2_sel0", 32'h40, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, term, rdat);
    xact("t2_rd0", 32'h40, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t2_sel0_value", rdat, 32'h11BB33DD);

    // Range boundary: first index past the RAM errors, last index acks.
    xact("t3_oor", 32'h1000, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t3_oor_err", 32'(term), 32'd2);
    check("t3_oor_hold", rdat, 32'h11BB33DD);
    xact("t3_max", 32'hFFC, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t3_max_ack", 32'(term), 32'd1);

    // Busy gives retry without touching the RAM.
    xact("t4_busy", 32'h10, 32'h12345678, 4'hF, 1'b1, 1'b1, term, rdat);
    check("t4_rty", 32'(term), 32'd3);
    xact("t4_rd1", 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t4_unchanged", rdat, 32'hDEADBEEF);
    xact("t4_wr", 32'h10, 32'h12345678, 4'hF, 1'b1, 1'b0, term, rdat);
    xact("t4_rd2", 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t4_written", rdat, 32'h12345678);

    // Abort in WAIT: no termination, no write.
    xact("t5_wr", 32'h20, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, term, rdat);
    xfer(32'h20, 32'h5, 4'hF, 1'b1, 1'b0, 1, term, cyc_n, rdat);
    check("t5_abort_term", 32'(term), 32'd0);
    xact("t5_rd", 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t5_old_value", rdat, 32'hCAFEF00D);

    // Reset while a write sits in WAIT.
    @(posedge clk); #1;
    bus.adr_i = 32'h20; bus.dat_i = 32'h0BADF00D; bus.sel_i = 4'hF; bus.we_i = 1'b1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    any_term = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o || bus.rty_o) any_term++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.ack_o || bus.err_o || bus.rty_o) any_term++;
    end
    check("t6_no_term", 32'(any_term), 32'd0);
    check("t6_dat_rst", bus.dat_o, 32'd0);
    model_dat       = 32'd0;
    model_dat_known = 1'b1;
    xact("t6_rd", 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, term, rdat);
    check("t6_old_value", rdat, 32'hCAFEF00D);

    // Zero wait states, request held: ack every second cycle.
    @(posedge clk); #1;
    bus0.adr_i = 32'h0; bus0.sel_i = 4'hF; bus0.we_i = 1'b0;
    bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1;
    @(posedge clk);
    pat = 8'h00;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      pat[n] = bus0.ack_o;
    end
    @(posedge clk); #1;
    bus0.cyc_i = 1'b0; bus0.stb_i = 1'b0;
    check("ws0_b2b_ack", 32'(pat), 32'h55);

    // Randomized transfers over a small window, misaligned, out of range and busy.
    for (int i = 0; i < 60; i++) begin
      k   = int'($urandom_range(0, 16));
      idx = (k == 16) ? 1023 : k;
      adr = 32'(idx * 4);
      case ($urandom_range(0, 9))
        0:       adr = adr | 32'($urandom_range(1, 3));
        1:       adr = adr | (32'($urandom_range(1, 1048575)) << 12);
        default: ;
      endcase
      xact("rnd", adr, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), term, rdat);
    end

    repeat (2) @(posedge clk);
    check("term_onehot_spacing", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
